// File: rtl/keypad_pkg.sv
// keypad_pkg: shared state encoding and matrix dimensions for the keypad scanner
package keypad_pkg;
    typedef enum logic [1:0] {IDLE, SCAN, EVAL, OUT} state_t;
    localparam int ROWS = 8;
    localparam int COLS = 8;
    localparam int CODE_W = 6;
endpackage

// File: rtl/key_debounce.sv
// key_debounce: frame-level candidate debouncer tracking the reported key and raising press/release events
module key_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              eval,
    input  logic [CODE_W-1:0] cand,
    input  logic              cand_v,
    output logic              ev,
    output logic [CODE_W-1:0] code,
    output logic              down
);
    logic [CODE_W-1:0] prev, rep;
    logic              prev_v, rep_v, same, differs;
    logic [3:0]        stable, stable_nx;
    always_comb begin
        same      = (cand_v == prev_v) && (!cand_v || cand == prev);
        stable_nx = !same ? 4'd0 : (stable == 4'hf) ? stable : stable + 4'd1;
        differs   = (cand_v != rep_v) || (cand_v && cand != rep);
        ev        = eval && (stable_nx >= 4'(DEBOUNCE - 1)) && differs;
        code      = rep_v ? rep : cand;
        down      = !rep_v;
    end
    // Any change while a key is reported is a release; a new key needs its own stable run.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev   <= '0;
            prev_v <= 1'b0;
            stable <= '0;
            rep    <= '0;
            rep_v  <= 1'b0;
        end else if (clr) begin
            prev   <= '0;
            prev_v <= 1'b0;
            stable <= '0;
        end else if (eval) begin
            prev   <= cand;
            prev_v <= cand_v;
            stable <= stable_nx;
            if (ev) begin
                rep   <= cand;
                rep_v <= !rep_v;
            end
        end
    end
endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: 8x8 row-scanning keypad controller with frame debounce and valid/ready event output
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int DWELL    = 16,
    parameter int DEBOUNCE = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic [2:0]        row_sel,
    input  logic [COLS-1:0]   col,
    output logic              key_valid,
    input  logic              key_ready,
    output logic [CODE_W-1:0] key_code,
    output logic              key_down,
    output logic              key_multi
);
    state_t                 state, state_nx;
    logic [7:0]             dwell;
    logic [ROWS*COLS-1:0]   frame;
    logic [CODE_W-1:0]      cand, ev_code;
    logic                   cand_v, multi, ev, ev_down, last, clr, eval;
    assign last = dwell == 8'(DWELL - 1);
    assign clr  = (state == SCAN) && !en;
    assign eval = state == EVAL;
    always_comb begin
        cand   = '0;
        cand_v = 1'b0;
        for (int i = ROWS*COLS-1; i >= 0; i--)
            if (frame[i]) begin
                cand   = CODE_W'(i);
                cand_v = 1'b1;
            end
        multi = $countones(frame) > 1;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: state_nx = en ? SCAN : IDLE;
            SCAN: state_nx = !en ? IDLE : (last && row_sel == 3'd7) ? EVAL : SCAN;
            EVAL: state_nx = ev ? OUT : en ? SCAN : IDLE;
            OUT:  state_nx = key_ready ? (en ? SCAN : IDLE) : OUT;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
    // row_sel wraps to 0 naturally after row 7, leaving it ready for EVAL/OUT.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_sel   <= '0;
            dwell     <= '0;
            frame     <= '0;
            key_valid <= 1'b0;
            key_code  <= '0;
            key_down  <= 1'b0;
            key_multi <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    row_sel <= '0;
                    dwell   <= '0;
                    frame   <= '0;
                end
                SCAN: begin
                    if (!en) begin
                        row_sel <= '0;
                        dwell   <= '0;
                        frame   <= '0;
                    end else if (last) begin
                        frame[{row_sel, 3'b000} +: COLS] <= col;
                        dwell   <= '0;
                        row_sel <= row_sel + 3'd1;
                    end else
                        dwell <= dwell + 8'd1;
                end
                EVAL: if (ev) begin
                    key_valid <= 1'b1;
                    key_code  <= ev_code;
                    key_down  <= ev_down;
                    key_multi <= multi;
                end
                OUT: if (key_ready) key_valid <= 1'b0;
                default: ;
            endcase
        end
    end
    key_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .eval   (eval),
        .cand   (cand),
        .cand_v (cand_v),
        .ev     (ev),
        .code   (ev_code),
        .down   (ev_down)
    );
endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: frame-level reference model check of keypad_scan with directed and random key patterns
module tb_keypad_scan;
    localparam int DEB = 3;
    logic        clk = 0, rst = 1, en = 0, key_ready = 0;
    logic [2:0]  row_sel;
    logic [7:0]  col;
    logic        key_valid, key_down, key_multi;
    logic [5:0]  key_code;
    logic [63:0] keys = '0;
    int checks = 0, errors = 0;
    int prev = -1, stable = 0, rep = -1;

    keypad_scan #(.DWELL(4), .DEBOUNCE(DEB)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .row_sel   (row_sel),
        .col       (col),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_code  (key_code),
        .key_down  (key_down),
        .key_multi (key_multi)
    );

    always #5 clk = ~clk;
    assign col = keys[{row_sel, 3'b000} +: 8];

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called on the first SCAN cycle of a frame; returns on the first SCAN cycle of the next.
    task automatic run_frame(input logic [63:0] k, input int hold, input bit abort);
        int cand, expc;
        bit mul, ev, dn;
        keys = k;
        for (int c = 0; c < 32; c++) begin
            check("row_sel", row_sel, c / 4);
            tick();
        end
        check("eval_row", row_sel, 0);
        check("eval_valid", key_valid, 0);
        tick();
        cand = -1;
        for (int i = 0; i < 64 && cand < 0; i++) if (k[i]) cand = i;
        mul = $countones(k) > 1;
        stable = (cand == prev) ? (stable < 15 ? stable + 1 : 15) : 0;
        prev = cand;
        ev = stable >= DEB - 1 && cand != rep;
        dn = 0;
        expc = 0;
        if (ev) begin
            dn = rep < 0;
            expc = dn ? cand : rep;
            rep = dn ? cand : -1;
        end
        check("key_valid", key_valid, ev);
        if (!ev) return;
        if (abort) begin
            rst = 1;
            tick();
            check("rst_valid", key_valid, 0);
            check("rst_code", key_code, 0);
            rst = 0;
            prev = -1; stable = 0; rep = -1;
            tick();
            return;
        end
        check("key_code", key_code, expc);
        check("key_down", key_down, dn);
        check("key_multi", key_multi, mul);
        repeat (hold) begin
            tick();
            check("hold_valid", key_valid, 1);
            check("hold_code", key_code, expc);
            check("hold_down", key_down, dn);
            check("hold_multi", key_multi, mul);
            check("hold_row", row_sel, 0);
        end
        key_ready = 1;
        tick();
        key_ready = 0;
        check("ack_valid", key_valid, 0);
    endtask

    initial begin
        logic [63:0] k;
        repeat (3) tick();
        rst = 0;
        tick();
        check("rst_row", row_sel, 0);
        check("rst_kv", key_valid, 0);
        check("rst_code", key_code, 0);
        check("rst_down", key_down, 0);
        check("rst_multi", key_multi, 0);
        en = 1;
        tick();
        run_frame('0, 0, 0);
        repeat (3) run_frame(64'd1 << 21, 10, 0);
        repeat (3) run_frame('0, 2, 0);
        repeat (2) run_frame(64'd1 << 21, 0, 0);
        repeat (3) run_frame('0, 0, 0);
        repeat (3) run_frame((64'd1 << 31) | (64'd1 << 8), 1, 0);
        repeat (3) run_frame('0, 0, 0);
        for (int r = 0; r < 25; r++) begin
            case ($urandom_range(0, 3))
                0: k = '0;
                1: k = 64'd1 << $urandom_range(0, 63);
                2: k = (64'd1 << $urandom_range(0, 63)) | (64'd1 << $urandom_range(0, 63));
                default: k = {$urandom(), $urandom()} & {$urandom(), $urandom()} & {$urandom(), $urandom()};
            endcase
            repeat ($urandom_range(1, 5)) run_frame(k, $urandom_range(0, 3), 0);
        end
        repeat (10) tick();
        en = 0;
        tick();
        check("drop_row", row_sel, 0);
        prev = -1; stable = 0;
        repeat (6) begin
            tick();
            check("idle_row", row_sel, 0);
            check("idle_valid", key_valid, 0);
        end
        en = 1;
        tick();
        repeat (3) run_frame('0, 0, 0);
        repeat (2) run_frame(64'd1 << 45, 0, 0);
        run_frame(64'd1 << 45, 0, 1);
        run_frame('0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
